// File: rtl/lock_pkg.sv
// Shared definitions for the password-lock digit path.
//   KEY_BKSP / KEY_DIGIT_MAX : key code classes produced by the keypad
//   KEY_BLANK                : blank nibble code used by the display controller
//   scan_state_e             : keypad scan FSM encoding
//   col_valid / low_idx      : column pattern helpers (active-low, 4 bits)
package lock_pkg;

    localparam logic [3:0] KEY_BKSP      = 4'hA;
    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0] KEY_BLANK     = 4'hE;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } scan_state_e;

    // Exactly one low bit; zero or several low bits are treated as "no key".
    function automatic logic col_valid(input logic [3:0] col);
        return ($countones(~col) == 1);
    endfunction

    // Index of the (single) low bit of an active-low one-cold vector.
    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with debounce.
//   clk_i, rst_i      : clock, async active-high reset
//   col_i             : raw column sense (async, active-low)
//   row_o             : row drive, one-cold
//   press_o           : high for the single PRESSED cycle
//   press_code_o      : code of the key being accepted (valid with press_o)
//   key_valid_o       : registered one-cycle pulse per debounced press
//   key_code_o        : code of the last debounced press
module keypad_scan
    import lock_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int DEB_CNT  = 20
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] col_i,
    output logic [3:0] row_o,
    output logic       press_o,
    output logic [3:0] press_code_o,
    output logic       key_valid_o,
    output logic [3:0] key_code_o
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEB_CNT + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    // Count value on which the next matching sample reaches DEB_CNT.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

    logic [3:0]  col_meta_q, col_s_q;
    logic [DW-1:0] div_q;
    logic        tick;
    scan_state_e state_q, state_d;
    logic [3:0]  row_q, row_d;
    logic [3:0]  col_lat_q, col_lat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        key_valid_q;
    logic [3:0]  key_code_q;

    assign tick = (div_q == DIV_LAST);

    // State register plus synchronizer, divider and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_meta_q  <= 4'hF;
            col_s_q     <= 4'hF;
            div_q       <= '0;
            state_q     <= ST_SCAN;
            row_q       <= 4'b1110;
            col_lat_q   <= 4'hF;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
        end else begin
            col_meta_q  <= col_i;
            col_s_q     <= col_meta_q;
            div_q       <= tick ? '0 : div_q + DW'(1);
            state_q     <= state_d;
            row_q       <= row_d;
            col_lat_q   <= col_lat_d;
            cnt_q       <= cnt_d;
            key_valid_q <= press_o;
            if (press_o) key_code_q <= press_code_o;
        end
    end

    // Next-state logic. Everything except PRESSED advances on a tick only.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_lat_d = col_lat_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_SCAN: if (tick) begin
                if (col_valid(col_s_q)) begin
                    col_lat_d = col_s_q;
                    cnt_d     = '0;
                    state_d   = ST_DEBOUNCE;
                end else begin
                    row_d = {row_q[2:0], row_q[3]};
                end
            end
            ST_DEBOUNCE: if (tick) begin
                if (col_s_q == col_lat_q) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_PRESSED;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    // Bounce: rescan starting from the same row.
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_PRESSED: begin
                cnt_d   = '0;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: if (tick) begin
                if (col_s_q == 4'hF) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_SCAN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    // Output logic.
    always_comb begin
        press_o      = (state_q == ST_PRESSED);
        press_code_o = {low_idx(row_q), low_idx(col_lat_q)};
    end

    assign row_o       = row_q;
    assign key_valid_o = key_valid_q;
    assign key_code_o  = key_code_q;

endmodule

// File: rtl/key_entry_ctrl.sv
// Keypad digit entry: scans the keypad and assembles up to three digits.
//   clk, rst   : clock, async active-high reset
//   key_row    : row drive (active-low), key_col : column sense (active-low)
//   enable     : apply digits/backspace to the buffer while high
//   clear      : one-cycle pulse, empties the buffer
//   num        : slot i in num[4i+3:4i]; seat bit i = slot i empty
//   full       : all three slots filled
//   key_valid  : one-cycle pulse per debounced press; key_code : its code
module key_entry_ctrl
    import lock_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int DEB_CNT  = 20
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  key_row,
    input  logic [3:0]  key_col,
    input  logic        enable,
    input  logic        clear,
    output logic [11:0] num,
    output logic [2:0]  seat,
    output logic        full,
    output logic        key_valid,
    output logic [3:0]  key_code
);

    logic        press;
    logic [3:0]  press_code;
    logic [11:0] num_q, num_d;
    logic [2:0]  seat_q, seat_d;
    logic        full_q;
    logic        done;

    keypad_scan #(
        .SCAN_DIV (SCAN_DIV),
        .DEB_CNT  (DEB_CNT)
    ) u_scan (
        .clk_i        (clk),
        .rst_i        (rst),
        .col_i        (key_col),
        .row_o        (key_row),
        .press_o      (press),
        .press_code_o (press_code),
        .key_valid_o  (key_valid),
        .key_code_o   (key_code)
    );

    // Slot buffer. Updated on the PRESSED cycle so it lands on the same edge
    // as key_valid; clear overrides a simultaneous press.
    always_comb begin
        num_d  = num_q;
        seat_d = seat_q;
        done   = 1'b0;
        if (clear) begin
            num_d  = 12'h000;
            seat_d = 3'b111;
        end else if (press && enable) begin
            if (press_code <= KEY_DIGIT_MAX) begin
                // Lowest empty slot; no empty slot means the digit is dropped.
                for (int i = 0; i < 3; i++) begin
                    if (!done && seat_q[i]) begin
                        num_d[4*i +: 4] = press_code;
                        seat_d[i]       = 1'b0;
                        done            = 1'b1;
                    end
                end
            end else if (press_code == KEY_BKSP) begin
                for (int i = 2; i >= 0; i--) begin
                    if (!done && !seat_q[i]) begin
                        num_d[4*i +: 4] = 4'h0;
                        seat_d[i]       = 1'b1;
                        done            = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q  <= 12'h000;
            seat_q <= 3'b111;
            full_q <= 1'b0;
        end else begin
            num_q  <= num_d;
            seat_q <= seat_d;
            full_q <= (seat_d == 3'b000);
        end
    end

    assign num  = num_q;
    assign seat = seat_q;
    assign full = full_q;

endmodule
